memory_key_sequencer: RTL
=========================

Name: memory_key_sequencer

Overview:
- Sits between the keypad decoder and the calculator memory register (store/clear strobes, 12-bit data in, stored number back).
- Turns raw memory-key levels (MS, MC, MR, M+, M-) into single-cycle, prioritised memory operations.
- Performs M+/M- read-modify-write with saturation.
- Returns recalled values to the display/entry logic over a valid/ready handshake.

Parameters:
- WIDTH, 12, width of display value, stored number and all datapaths.
- MAX_VAL, 4095, saturation ceiling for M+ (must equal 2^WIDTH-1 or less).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_ms  input  1  memory-store key level (already synchronised).
- key_mc  input  1  memory-clear key level.
- key_mr  input  1  memory-recall key level.
- key_mplus  input  1  memory-add key level.
- key_mminus  input  1  memory-subtract key level.
- display_value  input  WIDTH  number currently shown on the display.
- number_store  input  WIDTH  current contents of the memory register.
- mem_store  output  1  one-cycle store strobe to the memory register.
- mem_clear  output  1  one-cycle clear strobe to the memory register.
- mem_write_value  output  WIDTH  data presented to the memory register with mem_store.
- recall_valid  output  1  recall data valid.
- recall_value  output  WIDTH  recalled number.
- recall_ready  input  1  display/entry logic accepts the recall.
- busy  output  1  high in any state other than IDLE.
- mem_flag  output  1  memory nonzero ("M" indicator).
- sat_flag  output  1  sticky: last M+/M- saturated.

Behaviour:
- Reset:
  - State returns to IDLE.
  - mem_store, mem_clear, recall_valid and sat_flag go to 0.
  - mem_write_value, recall_value and mem_flag go to 0.
  - The key history registers load the current key levels, so keys held through reset do not fire on release.
  - Reset mid-operation aborts it: no strobe is issued and a pending recall is dropped.
- Edge detect:
  - A key event is key=1 while its history bit=0, both sampled at the same clock edge.
  - History bits update every cycle, including while busy.
  - Edges arriving while busy=1 are discarded, not queued.
- Priority for simultaneous edges in IDLE: MC > MS > M+ > M- > MR. Only the winner executes; the rest are discarded.
- States:
  - IDLE: wait for an event.
    - MC -> CLEAR.
    - MS -> STORE, with mem_write_value <= display_value latched at the detect edge.
    - M+ / M- -> ARITH, with the operand latched from display_value.
    - MR -> RECALL, with recall_value <= number_store.
  - CLEAR: mem_clear=1 for exactly one cycle; sat_flag <= 0; -> IDLE.
  - ARITH (one cycle):
    - M+: sum = number_store + operand at WIDTH+1 bits; if sum > MAX_VAL, result = MAX_VAL and sat_flag <= 1.
    - M-: if operand > number_store, result = 0 and sat_flag <= 1; else result = number_store - operand.
    - Non-saturating M+/M- leaves sat_flag unchanged.
    - mem_write_value <= result; -> STORE.
  - STORE: mem_store=1 for exactly one cycle with mem_write_value stable; -> IDLE. A direct MS store also clears sat_flag.
  - RECALL:
    - recall_valid=1, with recall_value held constant until the cycle recall_ready=1 is sampled.
    - recall_valid drops on the following cycle; -> IDLE.
    - Unbounded wait; no timeout.
- mem_store and mem_clear are never high together, and never high outside CLEAR/STORE.
- Latency:
  - MS edge at edge N gives mem_store high in cycle N+1.
  - M+/M- edge at N gives mem_store high in cycle N+2.
  - MC edge at N gives mem_clear high in cycle N+1.
- The memory register updates at the edge ending STORE/CLEAR. The following IDLE cycle sees the new number_store, so back-to-back ops are coherent.
- mem_flag is a register: mem_flag <= (number_store != 0) every cycle, so it lags number_store by one cycle.
- mem_write_value holds its last value outside STORE.

Test Plan:
- Reset, display_value=0x123, pulse key_ms one cycle -> mem_store high exactly 1 cycle with mem_write_value=0x123; after the memory updates, mem_flag=1 one cycle later.
- number_store=0xF00, display_value=0x200, pulse key_mplus -> mem_store in cycle N+2 with mem_write_value=0xFFF and sat_flag=1; then pulse key_mc -> mem_clear 1 cycle and sat_flag=0.
- number_store=0x010, display_value=0x020, pulse key_mminus -> mem_write_value=0x000 with sat_flag=1; with display_value=0x008 instead -> 0x008 and sat_flag unchanged.
- number_store=0x456, pulse key_mr, hold recall_ready=0 for 5 cycles then 1 -> recall_valid high throughout with recall_value=0x456; recall_valid low the cycle after ready is sampled; busy=1 for the whole wait.
- key_mc, key_ms and key_mr rise on the same edge -> only mem_clear fires; no mem_store, no recall_valid. Another key_ms edge during RECALL -> ignored.
- Hold key_ms high across reset assertion and release -> no mem_store. Assert reset during RECALL -> recall_valid=0 next cycle, state IDLE, all outputs 0.

Source files
------------

// File: rtl/memory_key_sequencer.sv
// rtl/memory_key_sequencer.sv - memory-key edge detect, priority select, M+/M- saturating update, recall handshake
module memory_key_sequencer #(
    parameter int WIDTH   = 12,
    parameter int MAX_VAL = 4095
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_ms,
    input  logic             key_mc,
    input  logic             key_mr,
    input  logic             key_mplus,
    input  logic             key_mminus,
    input  logic [WIDTH-1:0] display_value,
    input  logic [WIDTH-1:0] number_store,
    output logic             mem_store,
    output logic             mem_clear,
    output logic [WIDTH-1:0] mem_write_value,
    output logic             recall_valid,
    output logic [WIDTH-1:0] recall_value,
    input  logic             recall_ready,
    output logic             busy,
    output logic             mem_flag,
    output logic             sat_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STORE,
        S_ARITH,
        S_RECALL
    } state_t;

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    state_t           state_q, state_d;
    logic [4:0]       keys, hist_q, hist_d, evt;
    logic [WIDTH-1:0] wval_q, wval_d;
    logic [WIDTH-1:0] rval_q, rval_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             sub_q, sub_d;
    logic             sat_q, sat_d;
    logic             mflag_q, mflag_d;
    logic [WIDTH:0]   sum;

    // bit order: 0=MC 1=MS 2=M+ 3=M- 4=MR, also the priority order
    assign keys = {key_mr, key_mminus, key_mplus, key_ms, key_mc};

    always_comb begin
        state_d   = state_q;
        hist_d    = keys;
        wval_d    = wval_q;
        rval_d    = rval_q;
        operand_d = operand_q;
        sub_d     = sub_q;
        sat_d     = sat_q;
        mflag_d   = |number_store;
        evt       = keys & ~hist_q;
        sum       = {1'b0, number_store} + {1'b0, operand_q};

        case (state_q)
            S_IDLE: begin
                if (evt[0]) begin
                    state_d = S_CLEAR;
                end else if (evt[1]) begin
                    state_d = S_STORE;
                    wval_d  = display_value;
                    sat_d   = 1'b0;
                end else if (evt[2] || evt[3]) begin
                    state_d   = S_ARITH;
                    operand_d = display_value;
                    sub_d     = !evt[2];
                end else if (evt[4]) begin
                    state_d = S_RECALL;
                    rval_d  = number_store;
                end
            end
            S_CLEAR: begin
                sat_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_ARITH: begin
                if (sub_q) begin
                    if (operand_q > number_store) begin
                        wval_d = '0;
                        sat_d  = 1'b1;
                    end else begin
                        wval_d = number_store - operand_q;
                    end
                end else if (sum > MAX_EXT) begin
                    wval_d = MAX_W;
                    sat_d  = 1'b1;
                end else begin
                    wval_d = sum[WIDTH-1:0];
                end
                state_d = S_STORE;
            end
            S_STORE: begin
                state_d = S_IDLE;
            end
            S_RECALL: begin
                if (recall_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hist_q    <= keys;
            wval_q    <= '0;
            rval_q    <= '0;
            operand_q <= '0;
            sub_q     <= 1'b0;
            sat_q     <= 1'b0;
            mflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            wval_q    <= wval_d;
            rval_q    <= rval_d;
            operand_q <= operand_d;
            sub_q     <= sub_d;
            sat_q     <= sat_d;
            mflag_q   <= mflag_d;
        end
    end

    assign mem_store       = (state_q == S_STORE);
    assign mem_clear       = (state_q == S_CLEAR);
    assign recall_valid    = (state_q == S_RECALL);
    assign busy            = (state_q != S_IDLE);
    assign mem_write_value = wval_q;
    assign recall_value    = rval_q;
    assign mem_flag        = mflag_q;
    assign sat_flag        = sat_q;

endmodule
